ifmap_spad_loader: RTL and testbench

//   Upstream fill stage for the PE ifmap scratchpad. Accepts a valid/ready byte stream

---
 rtl/pe_pkg.sv | 23 ++
 rtl/spad_addr_counter.sv | 31 +++
 rtl/ifmap_spad_loader.sv | 98 +++++++++
 tb/tb_ifmap_spad_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE constants and types for the ifmap/filter/psum scratchpad loaders.
package pe_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spad_wr_t;

  // Burst lengths beyond the spad depth collapse to a full fill.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
  endfunction
endpackage

// File: rtl/spad_addr_counter.sv
// Loadable beat counter with base offset; address wraps modulo the spad depth.
module spad_addr_counter
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_inc,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_addr_c
);
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Truncation to ADDR_W bits gives the wrap for free.
  assign o_addr_c = r_base + r_count[ADDR_W-1:0];
  assign o_count  = r_count;
endmodule

// File: rtl/ifmap_spad_loader.sv
// Fills the PE ifmap scratchpad from a valid/ready byte stream, one burst per start.
module ifmap_spad_loader
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_load_len,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_spad_w_en,
  output logic [ADDR_W-1:0] o_spad_w_addr,
  output logic [DATA_W-1:0] o_spad_w_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);
  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_addr;
  logic              w_beat;
  logic              w_start_ok;
  logic              w_last;
  logic              r_w_en;
  logic              r_done;
  logic              r_busy;
  spad_wr_t          r_wr;

  spad_addr_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start_ok),
    .i_base   (i_base_addr),
    .i_inc    (w_beat),
    .o_count  (w_count),
    .o_addr_c (w_addr)
  );

  assign w_last = (w_count + CNT_W'(1)) == r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_beat     = 1'b0;
    o_in_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_ok = 1'b1;
          w_next     = (i_load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        o_in_ready = 1'b1;
        w_beat     = i_in_valid;
        // Abort wins over completion; an accepted beat is still written.
        if (i_abort)              w_next = IDLE;
        else if (w_beat && w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Write port and status registers; address/data hold between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_en <= 1'b0;
      r_wr   <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_w_en <= w_beat;
      if (w_beat)     r_wr  <= '{addr: w_addr, data: i_in_data};
      if (w_start_ok) r_len <= clamp_len(i_load_len);
      r_done <= (w_next == DONE);
      r_busy <= (w_next == LOAD);
    end
  end

  assign o_spad_w_en   = r_w_en;
  assign o_spad_w_addr = r_wr.addr;
  assign o_spad_w_data = r_wr.data;
  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign o_count       = w_count;
endmodule

// File: tb/tb_ifmap_spad_loader.sv
// Directed bench for ifmap_spad_loader: per-cycle vector table plus wrap, full-fill and reset sequences.
module tb_ifmap_spad_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] load_len;
  logic [5:0] base_addr;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       w_en;
  logic [5:0] w_addr;
  logic [7:0] w_data;
  logic       busy;
  logic       done;
  logic [6:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifmap_spad_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_load_len   (load_len),
    .i_base_addr  (base_addr),
    .i_abort      (abort),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_spad_w_en  (w_en),
    .o_spad_w_addr(w_addr),
    .o_spad_w_data(w_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_count      (count)
  );

  typedef struct {
    logic       start;
    logic [6:0] len;
    logic [5:0] base;
    logic       abort;
    logic       valid;
    logic [7:0] data;
    logic       e_wen;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    logic       e_done;
    logic       e_busy;
    logic       e_ready;
    logic [6:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [6:0] l, input logic [5:0] b, input logic ab,
                     input logic v, input logic [7:0] d, input logic ew, input logic [5:0] ea,
                     input logic [7:0] ed, input logic edn, input logic eb, input logic er,
                     input logic [6:0] ec);
    vec_t t;
    t.start = s; t.len = l; t.base = b; t.abort = ab; t.valid = v; t.data = d;
    t.e_wen = ew; t.e_addr = ea; t.e_data = ed; t.e_done = edn; t.e_busy = eb;
    t.e_ready = er; t.e_cnt = ec;
    vq.push_back(t);
  endtask

  task automatic idle_inputs();
    start = 1'b0; load_len = '0; base_addr = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
  endtask

  initial begin
    int nw;
    bit seen_done;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst w_en", int'(w_en), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst ready", int'(in_ready), 0);
    check("rst count", int'(count), 0);
    check("rst addr", int'(w_addr), 0);
    rst_n = 1'b1;
    tick();

    // Burst base 0 len 4, continuous; a start while busy is ignored.
    add(1, 4, 0, 0, 0, 8'd0,   0, 0, 8'd0,  0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 8'd11,  1, 0, 8'd11, 0, 1, 1, 1);
    add(1, 9, 33, 0, 1, 8'd22, 1, 1, 8'd22, 0, 1, 1, 2);
    add(0, 0, 0, 0, 1, 8'd33,  1, 2, 8'd33, 0, 1, 1, 3);
    add(0, 0, 0, 0, 1, 8'd44,  1, 3, 8'd44, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 8'd0,   0, 3, 8'd44, 0, 0, 0, 4);
    // len 3 with valid gaps at base 10.
    add(1, 3, 10, 0, 0, 8'd0,  0, 3, 8'd44, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 8'hA1,  1, 10, 8'hA1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 8'h55,  0, 10, 8'hA1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 8'h66,  0, 10, 8'hA1, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 8'hA2,  1, 11, 8'hA2, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 8'h77,  0, 11, 8'hA2, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 8'h88,  0, 11, 8'hA2, 0, 1, 1, 2);
    add(0, 0, 0, 0, 1, 8'hA3,  1, 12, 8'hA3, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 8'h99,  0, 12, 8'hA3, 0, 0, 0, 3);
    // Abort after two beats of len 6, beat in the abort cycle still lands.
    add(1, 6, 20, 0, 0, 8'd0,  0, 12, 8'hA3, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 8'hB1,  1, 20, 8'hB1, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 8'hB2,  1, 21, 8'hB2, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 8'hB3,  0, 21, 8'hB2, 0, 0, 0, 2);
    // Zero-length burst: done next cycle, no write.
    add(1, 0, 40, 0, 0, 8'd0,  0, 21, 8'hB2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 8'hC1,  0, 21, 8'hB2, 0, 0, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      start = vq[k].start; load_len = vq[k].len; base_addr = vq[k].base;
      abort = vq[k].abort; in_valid = vq[k].valid; in_data = vq[k].data;
      tick();
      check($sformatf("v%0d w_en", k),  int'(w_en),     int'(vq[k].e_wen));
      check($sformatf("v%0d addr", k),  int'(w_addr),   int'(vq[k].e_addr));
      check($sformatf("v%0d data", k),  int'(w_data),   int'(vq[k].e_data));
      check($sformatf("v%0d done", k),  int'(done),     int'(vq[k].e_done));
      check($sformatf("v%0d busy", k),  int'(busy),     int'(vq[k].e_busy));
      check($sformatf("v%0d ready", k), int'(in_ready), int'(vq[k].e_ready));
      check($sformatf("v%0d count", k), int'(count),    int'(vq[k].e_cnt));
    end
    idle_inputs();
    tick();

    // Wrap: base 60, len 8 -> 60..63, 0..3.
    start = 1'b1; load_len = 7'd8; base_addr = 6'd60;
    tick();
    start = 1'b0;
    check("wrap busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i * 3 + 1);
      tick();
      check($sformatf("wrap w_en %0d", i), int'(w_en), 1);
      check($sformatf("wrap addr %0d", i), int'(w_addr), (60 + i) % 64);
      check($sformatf("wrap data %0d", i), int'(w_data), i * 3 + 1);
      check($sformatf("wrap done %0d", i), int'(done), (i == 7) ? 1 : 0);
    end
    tick();
    check("wrap post w_en", int'(w_en), 0);
    check("wrap count", int'(count), 8);
    idle_inputs();
    tick();

    // load_len 100 clamps to a full 64-entry fill from base 5.
    start = 1'b1; load_len = 7'd100; base_addr = 6'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    nw = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      in_data = 8'(cyc);
      tick();
      if (w_en) begin
        check("full addr", int'(w_addr), (5 + nw) % 64);
        nw++;
      end
      if (done) seen_done = 1'b1;
    end
    check("full done seen", int'(seen_done), 1);
    check("full writes", nw, 64);
    check("full last addr", int'(w_addr), 4);
    check("full count", int'(count), 64);
    tick();
    check("full post w_en", int'(w_en), 0);
    idle_inputs();
    tick();

    // Reset after 3 of 5 beats: outputs clear without a clock edge.
    start = 1'b1; load_len = 7'd5; base_addr = 6'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hD0 + i);
      tick();
    end
    check("pre-rst w_en", int'(w_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst w_en", int'(w_en), 0);
    check("arst busy", int'(busy), 0);
    check("arst ready", int'(in_ready), 0);
    check("arst count", int'(count), 0);
    check("arst addr", int'(w_addr), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post-rst w_en %0d", i), int'(w_en), 0);
      check($sformatf("post-rst busy %0d", i), int'(busy), 0);
    end
    check("post-rst done", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
